// File: rtl/bb8051_pkg.sv
// Shared definitions for the bb8051 ALU writeback stage.
//   SFR_ACC/SFR_B/SFR_PSW : direct addresses of the locally held SFRs
//   PSW_CY/AC/OV/P        : bit positions inside PSW
//   wb_state_t            : writeback sequencer state encoding
package bb8051_pkg;

    localparam logic [7:0] SFR_ACC = 8'hE0;
    localparam logic [7:0] SFR_B   = 8'hF0;
    localparam logic [7:0] SFR_PSW = 8'hD0;

    localparam int PSW_CY = 7;
    localparam int PSW_AC = 6;
    localparam int PSW_OV = 2;
    localparam int PSW_P  = 0;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WR1  = 2'd1,
        WB_WR2  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/bb8051_wb_sfr_map.sv
// Classifies a destination {addr, sfr} as one of the SFRs held inside the
// writeback stage (ACC, B, PSW). Anything else goes out on the RAM port.
//   addr     in  destination address
//   sfr      in  1 = direct SFR space, 0 = internal RAM
//   is_acc   out destination is ACC
//   is_b     out destination is B
//   is_psw   out destination is PSW
//   is_local out any of the above
module bb8051_wb_sfr_map
    import bb8051_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              sfr,
    output logic              is_acc,
    output logic              is_b,
    output logic              is_psw,
    output logic              is_local
);

    assign is_acc   = sfr && (addr == ADDR_W'(SFR_ACC));
    assign is_b     = sfr && (addr == ADDR_W'(SFR_B));
    assign is_psw   = sfr && (addr == ADDR_W'(SFR_PSW));
    assign is_local = is_acc || is_b || is_psw;

endmodule

// File: rtl/bb8051_alu_wb.sv
// ALU result writeback stage. Commits ACC/B/PSW updates at the accept edge
// and sequences up to two internal-RAM / external-SFR writes over a req/ack
// port.
//   clk, rst                  clock, async active-low reset
//   wb_valid / wb_ready       result bundle handshake
//   des1, des2, des_acc       ALU data results
//   des_c, des_ac, des_ov     ALU flag results
//   wb_acc_en, wb_b_en        ACC / B write enables
//   wb_flag_msk               {CY,AC,OV} update enables
//   wb_d*_en/addr/sfr         destination 1/2 descriptors
//   ram_wr_req/addr/sfr/data  write port, held stable until ram_wr_ack
//   acc, b_reg, psw           architectural registers
//
// state   | meaning
// IDLE    | ready for a bundle, no write in flight
// WR1     | driving destination 1 on the write port
// WR2     | driving destination 2 on the write port
module bb8051_alu_wb
    import bb8051_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 8,
    parameter logic [DATA_W-1:0] PSW_RST = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [DATA_W-1:0] des1,
    input  logic [DATA_W-1:0] des2,
    input  logic [DATA_W-1:0] des_acc,
    input  logic              des_c,
    input  logic              des_ac,
    input  logic              des_ov,
    input  logic              wb_acc_en,
    input  logic              wb_b_en,
    input  logic [2:0]        wb_flag_msk,
    input  logic              wb_d1_en,
    input  logic              wb_d2_en,
    input  logic [ADDR_W-1:0] wb_d1_addr,
    input  logic [ADDR_W-1:0] wb_d2_addr,
    input  logic              wb_d1_sfr,
    input  logic              wb_d2_sfr,
    output logic              ram_wr_req,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_wr_sfr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic              ram_wr_ack,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] b_reg,
    output logic [DATA_W-1:0] psw
);

    wb_state_t         state, state_nxt;
    logic [DATA_W-1:1] psw_hi, psw_hi_nxt;
    logic              psw_p;
    logic [DATA_W-1:0] acc_nxt, b_nxt;

    logic [ADDR_W-1:0] d1_addr, d2_addr;
    logic [DATA_W-1:0] d1_data, d2_data;
    logic              d1_sfr, d2_sfr, d2_pend_q;

    logic d1_acc, d1_b, d1_psw, d1_local;
    logic d2_acc, d2_b, d2_psw, d2_local;
    logic accept, d1_pend, d2_pend;

    bb8051_wb_sfr_map #(.ADDR_W(ADDR_W)) u_map_d1 (
        .addr     (wb_d1_addr),
        .sfr      (wb_d1_sfr),
        .is_acc   (d1_acc),
        .is_b     (d1_b),
        .is_psw   (d1_psw),
        .is_local (d1_local)
    );

    bb8051_wb_sfr_map #(.ADDR_W(ADDR_W)) u_map_d2 (
        .addr     (wb_d2_addr),
        .sfr      (wb_d2_sfr),
        .is_acc   (d2_acc),
        .is_b     (d2_b),
        .is_psw   (d2_psw),
        .is_local (d2_local)
    );

    assign wb_ready = (state == WB_IDLE);
    assign accept   = wb_valid && wb_ready;
    assign d1_pend  = wb_d1_en && !d1_local;
    assign d2_pend  = wb_d2_en && !d2_local;

    // Architectural register updates. Later assignments override earlier
    // ones, giving the priority enables/flags < d1 < d2. PSW bit0 is not
    // part of psw_hi, so a direct PSW write can never reach it.
    always_comb begin
        acc_nxt    = acc;
        b_nxt      = b_reg;
        psw_hi_nxt = psw_hi;
        if (accept) begin
            if (wb_acc_en)      acc_nxt = des_acc;
            if (wb_b_en)        b_nxt   = des2;
            if (wb_flag_msk[2]) psw_hi_nxt[PSW_CY] = des_c;
            if (wb_flag_msk[1]) psw_hi_nxt[PSW_AC] = des_ac;
            if (wb_flag_msk[0]) psw_hi_nxt[PSW_OV] = des_ov;
            if (wb_d1_en) begin
                if (d1_acc) acc_nxt    = des1;
                if (d1_b)   b_nxt      = des1;
                if (d1_psw) psw_hi_nxt = des1[DATA_W-1:1];
            end
            if (wb_d2_en) begin
                if (d2_acc) acc_nxt    = des2;
                if (d2_b)   b_nxt      = des2;
                if (d2_psw) psw_hi_nxt = des2[DATA_W-1:1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    if (d1_pend)      state_nxt = WB_WR1;
                    else if (d2_pend) state_nxt = WB_WR2;
                    else              state_nxt = WB_IDLE;
                end
            end
            WB_WR1:  if (ram_wr_ack) state_nxt = d2_pend_q ? WB_WR2 : WB_IDLE;
            WB_WR2:  if (ram_wr_ack) state_nxt = WB_IDLE;
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Parity is taken from the next ACC value so P changes on the same edge
    // as ACC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WB_IDLE;
            acc       <= '0;
            b_reg     <= '0;
            psw_hi    <= PSW_RST[DATA_W-1:1];
            psw_p     <= 1'b0;
            d1_addr   <= '0;
            d1_data   <= '0;
            d1_sfr    <= 1'b0;
            d2_addr   <= '0;
            d2_data   <= '0;
            d2_sfr    <= 1'b0;
            d2_pend_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            b_reg  <= b_nxt;
            psw_hi <= psw_hi_nxt;
            psw_p  <= ^acc_nxt;
            if (accept) begin
                d1_addr   <= wb_d1_addr;
                d1_data   <= des1;
                d1_sfr    <= wb_d1_sfr;
                d2_addr   <= wb_d2_addr;
                d2_data   <= des2;
                d2_sfr    <= wb_d2_sfr;
                d2_pend_q <= d2_pend;
            end
        end
    end

    assign psw = {psw_hi, psw_p};

    // The request comes straight from state, so an async reset drops it at once.
    always_comb begin
        ram_wr_req  = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_wr_sfr  = 1'b0;
        case (state)
            WB_WR1: begin
                ram_wr_req  = 1'b1;
                ram_wr_addr = d1_addr;
                ram_wr_data = d1_data;
                ram_wr_sfr  = d1_sfr;
            end
            WB_WR2: begin
                ram_wr_req  = 1'b1;
                ram_wr_addr = d2_addr;
                ram_wr_data = d2_data;
                ram_wr_sfr  = d2_sfr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bb8051_alu_wb.sv
module tb_bb8051_alu_wb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wb_valid = 1'b0;
    logic       wb_ready;
    logic [7:0] des1 = '0, des2 = '0, des_acc = '0;
    logic       des_c = 1'b0, des_ac = 1'b0, des_ov = 1'b0;
    logic       wb_acc_en = 1'b0, wb_b_en = 1'b0;
    logic [2:0] wb_flag_msk = '0;
    logic       wb_d1_en = 1'b0, wb_d2_en = 1'b0;
    logic [7:0] wb_d1_addr = '0, wb_d2_addr = '0;
    logic       wb_d1_sfr = 1'b0, wb_d2_sfr = 1'b0;
    logic       ram_wr_req;
    logic [7:0] ram_wr_addr;
    logic       ram_wr_sfr;
    logic [7:0] ram_wr_data;
    logic       ram_wr_ack = 1'b0;
    logic [7:0] acc, b_reg, psw;

    bb8051_alu_wb dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .des1        (des1),
        .des2        (des2),
        .des_acc     (des_acc),
        .des_c       (des_c),
        .des_ac      (des_ac),
        .des_ov      (des_ov),
        .wb_acc_en   (wb_acc_en),
        .wb_b_en     (wb_b_en),
        .wb_flag_msk (wb_flag_msk),
        .wb_d1_en    (wb_d1_en),
        .wb_d2_en    (wb_d2_en),
        .wb_d1_addr  (wb_d1_addr),
        .wb_d2_addr  (wb_d2_addr),
        .wb_d1_sfr   (wb_d1_sfr),
        .wb_d2_sfr   (wb_d2_sfr),
        .ram_wr_req  (ram_wr_req),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_sfr  (ram_wr_sfr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_ack  (ram_wr_ack),
        .acc         (acc),
        .b_reg       (b_reg),
        .psw         (psw)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       sfr;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  ack_dly = 0;
    int  wait_cnt = 0;
    logic hold_valid = 1'b0;
    wr_t hold_w;
    wr_t cur_w;
    wr_t exp_w;
    int  n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        des1 = '0; des2 = '0; des_acc = '0;
        des_c = 1'b0; des_ac = 1'b0; des_ov = 1'b0;
        wb_acc_en = 1'b0; wb_b_en = 1'b0; wb_flag_msk = '0;
        wb_d1_en = 1'b0; wb_d2_en = 1'b0;
        wb_d1_addr = '0; wb_d2_addr = '0;
        wb_d1_sfr = 1'b0; wb_d2_sfr = 1'b0;
    endtask

    // Present the bundle for exactly one rising edge (stage is idle when called).
    task automatic go();
        @(negedge clk);
        wb_valid = 1'b1;
        @(posedge clk);
        #1 wb_valid = 1'b0;
    endtask

    // Count falling edges with wb_ready low; 100 means it never came back.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wb_ready) return;
            cnt++;
        end
    endtask

    // Write-port responder and scoreboard: decides ack for the next rising
    // edge, and every accepted write is popped and compared in issue order.
    always @(negedge clk) begin
        if (!rst) begin
            ram_wr_ack = 1'b0;
            wait_cnt   = 0;
            hold_valid = 1'b0;
        end else if (ram_wr_req) begin
            cur_w = {ram_wr_addr, ram_wr_data, ram_wr_sfr};
            if (hold_valid) begin
                checks++;
                assert (cur_w === hold_w) else begin
                    errors++;
                    $error("FAIL wr_stable observed %0h expected %0h", cur_w, hold_w);
                end
            end
            if (wait_cnt >= ack_dly) begin
                ram_wr_ack = 1'b1;
                wait_cnt   = 0;
                hold_valid = 1'b0;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL wr_unexpected observed %0h expected none", cur_w);
                end
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    checks++;
                    assert (cur_w === exp_w) else begin
                        errors++;
                        $error("FAIL wr_data observed %0h expected %0h", cur_w, exp_w);
                    end
                end
            end else begin
                ram_wr_ack = 1'b0;
                wait_cnt++;
                hold_valid = 1'b1;
                hold_w     = cur_w;
            end
        end else begin
            ram_wr_ack = 1'b0;
            wait_cnt   = 0;
            hold_valid = 1'b0;
        end
    end

    initial begin
        // reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_acc", acc, 8'h00);
        chk("rst_b", b_reg, 8'h00);
        chk("rst_psw", psw, 8'h00);
        chk("rst_ready", wb_ready, 1'b1);
        chk("rst_req", ram_wr_req, 1'b0);

        // ADD: 81h has even parity, so P=0 -> CY|OV = 84h
        clr();
        wb_acc_en = 1'b1; des_acc = 8'h81;
        wb_flag_msk = 3'b111; des_c = 1'b1; des_ac = 1'b0; des_ov = 1'b1;
        go();
        @(negedge clk);
        chk("add_acc", acc, 8'h81);
        chk("add_psw", psw, 8'h84);
        chk("add_ready", wb_ready, 1'b1);
        chk("add_req", ram_wr_req, 1'b0);

        // XCH: two RAM writes, each acked after 2 wait cycles; a bundle
        // offered while busy must be ignored
        clr();
        wb_d1_en = 1'b1; wb_d1_addr = 8'h30; des1 = 8'h55;
        wb_d2_en = 1'b1; wb_d2_addr = 8'h31; des2 = 8'hAA;
        ack_dly = 2;
        exp_q.push_back({8'h30, 8'h55, 1'b0});
        exp_q.push_back({8'h31, 8'hAA, 1'b0});
        go();
        clr();
        wb_acc_en = 1'b1; des_acc = 8'hFF; wb_valid = 1'b1;
        wait_ready(n);
        wb_valid = 1'b0;
        clr();
        chk("xch_busy_cycles", n, 6);
        chk("xch_ignore_acc", acc, 8'h81);
        chk("xch_q_empty", exp_q.size(), 0);

        // MOV PSW: bit0 comes from ^ACC (03h -> 0), not from des1
        ack_dly = 0;
        clr();
        wb_acc_en = 1'b1; des_acc = 8'h03;
        wb_d1_en = 1'b1; wb_d1_addr = 8'hD0; wb_d1_sfr = 1'b1; des1 = 8'h19;
        go();
        @(negedge clk);
        chk("mov_psw", psw, 8'h18);
        chk("mov_acc", acc, 8'h03);
        chk("mov_ready", wb_ready, 1'b1);
        chk("mov_req", ram_wr_req, 1'b0);

        // Priority: acc_en/b_en lose to d1 (B<-77), d1 loses to d2 (ACC<-12)
        clr();
        wb_acc_en = 1'b1; des_acc = 8'h34;
        wb_b_en = 1'b1; des2 = 8'h12;
        wb_flag_msk = 3'b100; des_c = 1'b1;
        wb_d1_en = 1'b1; wb_d1_addr = 8'hF0; wb_d1_sfr = 1'b1; des1 = 8'h77;
        wb_d2_en = 1'b1; wb_d2_addr = 8'hE0; wb_d2_sfr = 1'b1;
        go();
        @(negedge clk);
        chk("pri_acc", acc, 8'h12);
        chk("pri_b", b_reg, 8'h77);
        chk("pri_psw", psw, 8'h98);
        chk("pri_req", ram_wr_req, 1'b0);

        // Non-local SFR goes out on the port with sfr=1
        clr();
        wb_d1_en = 1'b1; wb_d1_addr = 8'h90; wb_d1_sfr = 1'b1; des1 = 8'h5A;
        exp_q.push_back({8'h90, 8'h5A, 1'b1});
        go();
        wait_ready(n);
        chk("xsfr_busy_cycles", n, 1);
        chk("xsfr_acc", acc, 8'h12);

        // Same RAM address twice, immediate acks: 11 then 22 in two cycles
        clr();
        wb_d1_en = 1'b1; wb_d1_addr = 8'h40; des1 = 8'h11;
        wb_d2_en = 1'b1; wb_d2_addr = 8'h40; des2 = 8'h22;
        exp_q.push_back({8'h40, 8'h11, 1'b0});
        exp_q.push_back({8'h40, 8'h22, 1'b0});
        go();
        wait_ready(n);
        chk("dup_busy_cycles", n, 2);
        chk("dup_q_empty", exp_q.size(), 0);

        // Reset during WR1: request drops without a clock edge
        clr();
        wb_d1_en = 1'b1; wb_d1_addr = 8'h50; des1 = 8'h66;
        ack_dly = 20;
        exp_q.push_back({8'h50, 8'h66, 1'b0});
        go();
        clr();
        @(negedge clk);
        chk("wr1_req", ram_wr_req, 1'b1);
        chk("wr1_addr", ram_wr_addr, 8'h50);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", ram_wr_req, 1'b0);
        chk("arst_ready", wb_ready, 1'b1);
        chk("arst_acc", acc, 8'h00);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        ack_dly = 0;
        @(negedge clk);
        chk("post_ready", wb_ready, 1'b1);
        chk("post_req", ram_wr_req, 1'b0);
        chk("post_acc", acc, 8'h00);
        chk("post_b", b_reg, 8'h00);
        chk("post_psw", psw, 8'h00);
        repeat (3) @(negedge clk);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
